lcd_responder: RTL and testbench

- Synthesizable HD44780-compatible LCD model: the display end of the parallel E/RS/RW/DB bus that `lcd_controller` drives.
- Decodes instruction and data writes on the falling edge of E and holds 2×40 bytes of DDRAM plus display state.
- Answers busy-flag/address and data reads, and mirrors the first 16 visible characters of each line as flat 128-bit buses.
- Used as the loop-back target in controller benches and in on-chip self-test builds that have no physical panel.

---
 rtl/lcd_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-compatible display model for the E/RS/RW/DB bus.
// Holds 2x40 bytes of DDRAM and the display state. Writes are decoded on the
// falling edge of E. Reads are answered combinationally while E is high.
// The first 16 visible characters of each line are mirrored onto LineA/LineB.
module lcd_responder #(
    parameter int INS_BUSY_CYCLES = 37,
    parameter int CLR_BUSY_CYCLES = 1520
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         E,
    input  logic         RS,
    input  logic         RW,
    input  logic [7:0]   DB_in,
    output logic [7:0]   DB_out,
    output logic         DB_oe,
    output logic [127:0] LineA,
    output logic [127:0] LineB,
    output logic [6:0]   addr,
    output logic         busy,
    output logic         display_on,
    output logic         cursor_on,
    output logic         blink_on,
    output logic         inc_mode,
    output logic         shift_mode,
    output logic         two_line,
    output logic         data_8bit,
    output logic [5:0]   shift_offset,
    output logic         overrun
);

    localparam int CW = $clog2(CLR_BUSY_CYCLES + 1);
    localparam logic [CW-1:0] INS_N = CW'(INS_BUSY_CYCLES);
    localparam logic [CW-1:0] CLR_N = CW'(CLR_BUSY_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    // Legal DDRAM addresses: 0x00-0x27 (line 1) and 0x40-0x67 (line 2).
    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Map a legal DDRAM address to a linear storage index 0..79.
    function automatic logic [6:0] ram_idx(input logic [6:0] a);
        return a[6] ? (7'd40 + {1'b0, a[5:0]}) : a;
    endfunction

    // Address counter step: CG mode wraps mod 64, legal DDRAM addresses hop
    // between the two lines, anything else wraps as a plain 7-bit counter.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic cg);
        logic [6:0] r;
        if (cg) begin
            r = {1'b0, (up ? a[5:0] + 6'd1 : a[5:0] - 6'd1)};
        end else if (ac_valid(a)) begin
            if (up) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            else    r = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
        end else begin
            r = up ? a + 7'd1 : a - 7'd1;
        end
        return r;
    endfunction

    // Display shift offset step, modulo 40.
    function automatic logic [5:0] off_step(input logic [5:0] o, input logic up);
        if (up) return (o == 6'd39) ? 6'd0 : o + 6'd1;
        return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

    logic          e_q, rs_l_q, rw_l_q;
    logic [7:0]    db_l_q;
    logic [6:0]    ac_q, ac_d;
    logic          cg_q, cg_d;
    logic          disp_q, disp_d, cur_q, cur_d, blk_q, blk_d;
    logic          inc_q, inc_d, shm_q, shm_d, two_q, two_d, d8_q, d8_d;
    logic [5:0]    off_q, off_d;
    logic          ov_q, ov_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [7:0]    ram_q [0:79];
    logic          ram_we, ram_clr;
    logic [6:0]    ram_wa;
    logic          fall;

    assign fall   = e_q & ~E;
    assign busy   = (bcnt_q != '0);
    assign ram_wa = ram_idx(ac_q);

    // Decode the captured bus cycle on the fall of E into next-state values.
    always_comb begin
        ac_d    = ac_q;
        cg_d    = cg_q;
        disp_d  = disp_q;
        cur_d   = cur_q;
        blk_d   = blk_q;
        inc_d   = inc_q;
        shm_d   = shm_q;
        two_d   = two_q;
        d8_d    = d8_q;
        off_d   = off_q;
        ov_d    = ov_q;
        bcnt_d  = busy ? bcnt_q - ONE : bcnt_q;
        ram_we  = 1'b0;
        ram_clr = 1'b0;
        if (fall && !rw_l_q) begin
            if (busy) begin
                ov_d = 1'b1;
            end else begin
                bcnt_d = INS_N;
                if (rs_l_q) begin
                    ram_we = !cg_q && ac_valid(ac_q);
                    ac_d   = ac_step(ac_q, inc_q, cg_q);
                    if (shm_q) off_d = off_step(off_q, inc_q);
                end else begin
                    casez (db_l_q)
                        8'b1???????: begin ac_d = db_l_q[6:0]; cg_d = 1'b0; end
                        8'b01??????: begin ac_d = {1'b0, db_l_q[5:0]}; cg_d = 1'b1; end
                        8'b001?????: begin d8_d = db_l_q[4]; two_d = db_l_q[3]; end
                        8'b0001????: begin
                            if (db_l_q[3]) off_d = off_step(off_q, !db_l_q[2]);
                            else           ac_d  = ac_step(ac_q, db_l_q[2], cg_q);
                        end
                        8'b00001???: begin
                            disp_d = db_l_q[2];
                            cur_d  = db_l_q[1];
                            blk_d  = db_l_q[0];
                        end
                        8'b000001??: begin inc_d = db_l_q[1]; shm_d = db_l_q[0]; end
                        8'b0000001?: begin ac_d = 7'd0; off_d = 6'd0; bcnt_d = CLR_N; end
                        8'b00000001: begin
                            ram_clr = 1'b1;
                            ac_d    = 7'd0;
                            inc_d   = 1'b1;
                            off_d   = 6'd0;
                            bcnt_d  = CLR_N;
                        end
                        default: ;
                    endcase
                end
            end
        end else if (fall && rs_l_q) begin
            // Data read completed: AC advances, display does not shift.
            ac_d = ac_step(ac_q, inc_q, cg_q);
        end
    end

    // State registers and bus-strobe capture.
    always_ff @(posedge mclk) begin
        if (rst) begin
            e_q    <= 1'b0;
            rs_l_q <= 1'b0;
            rw_l_q <= 1'b0;
            db_l_q <= 8'h00;
            ac_q   <= 7'd0;
            cg_q   <= 1'b0;
            disp_q <= 1'b0;
            cur_q  <= 1'b0;
            blk_q  <= 1'b0;
            inc_q  <= 1'b1;
            shm_q  <= 1'b0;
            two_q  <= 1'b0;
            d8_q   <= 1'b1;
            off_q  <= 6'd0;
            ov_q   <= 1'b0;
            bcnt_q <= '0;
        end else begin
            e_q <= E;
            if (E) begin
                rs_l_q <= RS;
                rw_l_q <= RW;
                db_l_q <= DB_in;
            end
            ac_q   <= ac_d;
            cg_q   <= cg_d;
            disp_q <= disp_d;
            cur_q  <= cur_d;
            blk_q  <= blk_d;
            inc_q  <= inc_d;
            shm_q  <= shm_d;
            two_q  <= two_d;
            d8_q   <= d8_d;
            off_q  <= off_d;
            ov_q   <= ov_d;
            bcnt_q <= bcnt_d;
        end
    end

    // DDRAM: whole-array fill with spaces on reset/clear, else one byte write.
    always_ff @(posedge mclk) begin
        if (rst || ram_clr) begin
            for (int i = 0; i < 80; i++) ram_q[i] <= 8'h20;
        end else if (ram_we) begin
            ram_q[ram_wa] <= db_l_q;
        end
    end

    // Read path driven straight from the live bus inputs while E is high.
    always_comb begin
        DB_oe  = E & RW;
        DB_out = 8'h00;
        if (E && RW) begin
            if (!RS)                          DB_out = {busy, ac_q};
            else if (!cg_q && ac_valid(ac_q)) DB_out = ram_q[ram_wa];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_mirror
            logic [6:0] sum;
            logic [6:0] col;
            assign sum = {1'b0, off_q} + 7'(gi);
            assign col = (sum >= 7'd40) ? sum - 7'd40 : sum;
            assign LineA[8*gi +: 8] = ram_q[col];
            assign LineB[8*gi +: 8] = ram_q[col + 7'd40];
        end
    endgenerate

    assign addr         = ac_q;
    assign display_on   = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blk_q;
    assign inc_mode     = inc_q;
    assign shift_mode   = shm_q;
    assign two_line     = two_q;
    assign data_8bit    = d8_q;
    assign shift_offset = off_q;
    assign overrun      = ov_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Testbench for lcd_responder: table vectors for the init/text sequence,
// hand-written corner sequences, then randomized traffic against a
// transaction-level model of the display.
module tb_lcd_responder;

    localparam int INS = 37;
    localparam int CLR = 1520;

    logic         mclk = 1'b0;
    logic         rst  = 1'b1;
    logic         E = 1'b0, RS = 1'b0, RW = 1'b0;
    logic [7:0]   DB_in = 8'h00;
    logic [7:0]   DB_out;
    logic         DB_oe;
    logic [127:0] LineA, LineB;
    logic [6:0]   addr;
    logic         busy, display_on, cursor_on, blink_on, inc_mode, shift_mode;
    logic         two_line, data_8bit, overrun;
    logic [5:0]   shift_offset;

    lcd_responder #(.INS_BUSY_CYCLES(INS), .CLR_BUSY_CYCLES(CLR)) dut (
        .mclk(mclk), .rst(rst), .E(E), .RS(RS), .RW(RW), .DB_in(DB_in),
        .DB_out(DB_out), .DB_oe(DB_oe), .LineA(LineA), .LineB(LineB),
        .addr(addr), .busy(busy), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .inc_mode(inc_mode), .shift_mode(shift_mode),
        .two_line(two_line), .data_8bit(data_8bit), .shift_offset(shift_offset),
        .overrun(overrun)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // DDRAM kept as 80 linear cells: line*40 + column.
    logic [7:0] m_ram [0:79];
    logic [6:0] m_ac;
    bit m_cg, m_disp, m_cur, m_blk, m_inc, m_sh, m_two, m_d8, m_ov;
    int m_off;
    int busy_end;   // busy is high after edge j while j < busy_end

    function automatic int pos_of(input logic [6:0] a);
        int ai = int'(a);
        if (ai < 40) return ai;
        if (ai >= 64 && ai < 104) return ai - 24;
        return -1;
    endfunction

    function automatic logic [6:0] ac_of(input int p);
        return 7'(p < 40 ? p : p + 24);
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
        int ai = int'(a);
        int p  = pos_of(a);
        if (m_cg) return 7'(((ai % 64) + (up ? 1 : 63)) % 64);
        if (p >= 0) return ac_of((p + (up ? 1 : 79)) % 80);
        return 7'((ai + (up ? 1 : 127)) % 128);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
        m_ac = 0; m_cg = 0; m_disp = 0; m_cur = 0; m_blk = 0;
        m_inc = 1; m_sh = 0; m_two = 0; m_d8 = 1; m_ov = 0; m_off = 0;
        busy_end = 0;
    endtask

    task automatic model_fall(input int k, input bit rs, input bit rw, input logic [7:0] db);
        int p;
        if (rw) begin
            if (rs) m_ac = m_step(m_ac, m_inc);
            return;
        end
        if (k <= busy_end) begin
            m_ov = 1;
            return;
        end
        busy_end = k + INS;
        if (rs) begin
            p = pos_of(m_ac);
            if (!m_cg && p >= 0) m_ram[p] = db;
            m_ac = m_step(m_ac, m_inc);
            if (m_sh) m_off = (m_off + (m_inc ? 1 : 39)) % 40;
        end else if (db >= 8'h80) begin
            m_ac = db[6:0]; m_cg = 0;
        end else if (db >= 8'h40) begin
            m_ac = {1'b0, db[5:0]}; m_cg = 1;
        end else if (db >= 8'h20) begin
            m_d8 = db[4]; m_two = db[3];
        end else if (db >= 8'h10) begin
            if (db[3]) m_off = (m_off + (db[2] ? 39 : 1)) % 40;
            else       m_ac  = m_step(m_ac, db[2]);
        end else if (db >= 8'h08) begin
            m_disp = db[2]; m_cur = db[1]; m_blk = db[0];
        end else if (db >= 8'h04) begin
            m_inc = db[1]; m_sh = db[0];
        end else if (db >= 8'h02) begin
            m_ac = 0; m_off = 0; busy_end = k + CLR;
        end else if (db == 8'h01) begin
            for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
            m_ac = 0; m_inc = 1; m_off = 0; busy_end = k + CLR;
        end
    endtask

    function automatic logic [7:0] model_read(input bit rs);
        int p = pos_of(m_ac);
        if (!rs) return {(cyc < busy_end) ? 1'b1 : 1'b0, m_ac};
        if (m_cg || p < 0) return 8'h00;
        return m_ram[p];
    endfunction

    // Compare every observable output against the model (E low).
    task automatic check_all(input string tag);
        logic [127:0] ea, eb;
        for (int i = 0; i < 16; i++) begin
            ea[8*i +: 8] = m_ram[(i + m_off) % 40];
            eb[8*i +: 8] = m_ram[40 + (i + m_off) % 40];
        end
        chk({tag, ".LineA"}, LineA, ea);
        chk({tag, ".LineB"}, LineB, eb);
        chk({tag, ".addr"}, addr, m_ac);
        chk({tag, ".busy"}, busy, (cyc < busy_end) ? 1 : 0);
        chk({tag, ".flags"}, {display_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, data_8bit},
            {m_disp, m_cur, m_blk, m_inc, m_sh, m_two, m_d8});
        chk({tag, ".shift_offset"}, shift_offset, m_off);
        chk({tag, ".overrun"}, overrun, m_ov);
        chk({tag, ".DB_oe_idle"}, DB_oe, 0);
        chk({tag, ".DB_out_idle"}, DB_out, 0);
    endtask

    // One bus transaction, starting and ending on a falling clock edge.
    // E is held for w cycles; gap is the number of cycles waited after the
    // fall edge before the outputs are compared.
    task automatic xact(input bit rs, input bit rw, input logic [7:0] db, input int w, input int gap);
        int k;
        E = 1; RS = rs; RW = rw; DB_in = db;
        if (rw) begin
            #1;
            chk("read.DB_oe", DB_oe, 1);
            chk(rs ? "read.data" : "read.status", DB_out, model_read(rs));
        end
        repeat (w) @(negedge mclk);
        E = 0; RS = 0; RW = 0; DB_in = 8'h00;
        k = cyc + 1;
        model_fall(k, rs, rw, db);
        repeat (gap) @(negedge mclk);
        check_all("xact");
        $display("xact edge=%0d rs=%0b rw=%0b db=%02h addr=%02h busy=%0b ovr=%0b",
                 k, rs, rw, db, addr, busy, overrun);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge mclk);
        rst = 0;
        model_reset();
    endtask

    // Count consecutive sampled cycles with busy high.
    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge mclk);
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] db;
        logic [6:0] exp_addr;
        logic [7:0] exp_flags; // {disp,cur,blk,inc,shift,two_line,data_8bit,overrun}
    } vec_t;

    vec_t vecs [6];
    int   n;
    logic [127:0] exp_line;

    initial begin
        vecs[0] = '{1'b0, 8'h38, 7'h00, 8'h16};
        vecs[1] = '{1'b0, 8'h0F, 7'h00, 8'hF6};
        vecs[2] = '{1'b0, 8'h06, 7'h00, 8'hF6};
        vecs[3] = '{1'b0, 8'h80, 7'h00, 8'hF6};
        vecs[4] = '{1'b1, 8'h48, 7'h01, 8'hF6};
        vecs[5] = '{1'b1, 8'h49, 7'h02, 8'hF6};

        model_reset();
        repeat (3) @(negedge mclk);
        rst = 0;
        @(negedge mclk);
        check_all("reset");
        chk("reset.LineA", LineA, {16{8'h20}});
        chk("reset.flags", {display_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, data_8bit, overrun}, 8'h12);

        // Init and text from the table.
        for (int i = 0; i < 6; i++) begin
            xact(vecs[i].rs, 1'b0, vecs[i].db, 1, 40);
            chk($sformatf("vec%0d.addr", i), addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d.flags", i),
                {display_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, data_8bit, overrun},
                vecs[i].exp_flags);
        end
        chk("text.LineA", LineA[15:0], 16'h4948);

        // Busy length of an ordinary instruction.
        xact(1'b0, 1'b0, 8'h38, 1, 1);
        busy_len(n);
        chk("busy_len_ins", n, INS);

        // Line 2 fill and wrap from 0x67 to 0x00.
        xact(1'b0, 1'b0, 8'hC0, 1, 40);
        for (int i = 0; i < 16; i++) begin
            xact(1'b1, 1'b0, 8'(8'h41 + i), 1, 40);
            exp_line[8*i +: 8] = 8'(8'h41 + i);
        end
        chk("line2.LineB", LineB, exp_line);
        chk("line2.addr", addr, 7'h50);
        xact(1'b0, 1'b0, 8'hE7, 1, 40);
        xact(1'b1, 1'b0, 8'h7E, 1, 40);
        chk("wrap.addr", addr, 7'h00);

        // Write while busy is dropped and flagged.
        xact(1'b0, 1'b0, 8'h80, 1, 10);
        xact(1'b1, 1'b0, 8'h5A, 1, 40);
        chk("overrun.ram0", LineA[7:0], 8'h48);
        chk("overrun.flag", overrun, 1);

        // Status read while busy right after a data write at AC=2.
        xact(1'b0, 1'b0, 8'h82, 1, 40);
        xact(1'b1, 1'b0, 8'h43, 1, 5);
        E = 1; RS = 0; RW = 1;
        #1;
        chk("status.DB_oe", DB_oe, 1);
        chk("status.DB_out", DB_out, 8'h83);
        @(negedge mclk);
        E = 0; RW = 0;
        repeat (40) @(negedge mclk);

        // Clear display, then reset in the middle of its busy period.
        xact(1'b0, 1'b0, 8'h01, 1, 1);
        chk("clear.LineA", LineA, {16{8'h20}});
        chk("clear.LineB", LineB, {16{8'h20}});
        chk("clear.addr", addr, 7'h00);
        chk("clear.busy", busy, 1);
        repeat (498) @(negedge mclk);
        chk("clear.busy_mid", busy, 1);
        do_reset();
        chk("rst_mid_busy.busy", busy, 0);
        check_all("rst_mid_busy");

        // Return home holds busy for the long duration.
        xact(1'b0, 1'b0, 8'h02, 1, 1);
        busy_len(n);
        chk("busy_len_home", n, CLR);

        // Fall on the very edge where busy expires is rejected; one later is accepted.
        do_reset();
        xact(1'b0, 1'b0, 8'h38, 1, INS - 1);
        xact(1'b0, 1'b0, 8'h0C, 1, 40);
        chk("edge_expiry.overrun", overrun, 1);
        do_reset();
        xact(1'b0, 1'b0, 8'h38, 1, INS);
        xact(1'b0, 1'b0, 8'h0C, 1, 40);
        chk("after_expiry.overrun", overrun, 0);
        chk("after_expiry.display_on", display_on, 1);

        // Display shift via shift_mode on data writes.
        do_reset();
        xact(1'b0, 1'b0, 8'h83, 1, 40);
        xact(1'b1, 1'b0, 8'h77, 1, 40);
        xact(1'b0, 1'b0, 8'h80, 1, 40);
        xact(1'b0, 1'b0, 8'h07, 1, 40);
        for (int i = 0; i < 3; i++) xact(1'b1, 1'b0, 8'(8'h61 + i), 1, 40);
        chk("shift.offset", shift_offset, 6'd3);
        chk("shift.LineA0", LineA[7:0], 8'h77);

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 300; t++) begin
            int op  = $urandom_range(0, 9);
            int w   = $urandom_range(1, 3);
            int gap = $urandom_range(1, 45);
            logic [7:0] db = 8'($urandom_range(4, 255));
            if (op <= 3) begin
                if ($urandom_range(0, 60) == 0) db = 8'h01;
                xact(1'b0, 1'b0, db, w, gap);
            end else if (op <= 6) xact(1'b1, 1'b0, 8'($urandom), w, gap);
            else if (op == 7)     xact(1'b1, 1'b1, 8'($urandom), w, gap);
            else if (op == 8)     xact(1'b0, 1'b1, 8'($urandom), w, gap);
            else                  xact(1'b0, 1'b0, db, w, 40);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
